// File: rtl/camo_pkg.sv
// Shared types and constants for the camouflaged-gate key loader.
// Optional even-parity key check is enabled with `define CAMO_KEY_PARITY_EN.
package camo_pkg;

  localparam int KEY_BITS_PER_CELL = 2;

  typedef enum logic [1:0] {
    PASS   = 2'b00,
    INV    = 2'b10,
    CONST1 = 2'b01,
    CONST0 = 2'b11
  } cell_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_LOCKED = 2'd3
  } loader_state_t;

  // Number of serial bits in one load: the key plus an optional parity bit.
  function automatic int shadow_bits(input int n_cells, input bit parity_en);
    return KEY_BITS_PER_CELL * n_cells + (parity_en ? 1 : 0);
  endfunction

endpackage

// File: rtl/camo_key_shift.sv
// Serial-to-parallel shadow register: bit cnt of the stream lands in data[cnt].
// Shadow width already includes the parity bit when CAMO_KEY_PARITY_EN is set.
module camo_key_shift
  import camo_pkg::*;
#(
  parameter int WIDTH = 30,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data,
  output logic             last,
  output logic             full
);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          write_ok;

  assign full     = (cnt_reg == CW'(WIDTH));
  assign last     = (cnt_reg == CW'(WIDTH - 1));
  assign write_ok = wr_en & ~full;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (write_ok) begin
      cnt_next = cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // One flop per bit, each enabled only when the counter points at it.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          data[gi] <= 1'b0;
        end else if (clr) begin
          data[gi] <= 1'b0;
        end else if (write_ok && (cnt_reg == CW'(gi))) begin
          data[gi] <= bit_in;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/camo_key_loader.sv
// Key loader FSM: stream into shadow, check, commit atomically to key_o, optional lock.
// Build with `define CAMO_KEY_PARITY_EN to require a trailing even-parity bit.
module camo_key_loader
  import camo_pkg::*;
#(
  parameter int N_CELLS = 15
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load_start_i,
  input  logic                             key_valid_i,
  input  logic                             key_bit_i,
  output logic                             key_ready_o,
  input  logic                             lock_i,
  output logic [KEY_BITS_PER_CELL*N_CELLS-1:0] key_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o,
  output logic                             locked_o
);

  localparam int KEY_W = KEY_BITS_PER_CELL * N_CELLS;
`ifdef CAMO_KEY_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif
  localparam int SH_W = shadow_bits(N_CELLS, PARITY_EN);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_LOAD   = ST_LOAD;
  localparam logic [1:0] S_CHECK  = ST_CHECK;
  localparam logic [1:0] S_LOCKED = ST_LOCKED;

  logic [1:0]      state_reg, state_next;
  logic            ready_reg;
  logic [KEY_W-1:0] key_reg;
  logic            done_reg;
  logic            locked_reg;
  logic            sh_clr;
  logic            transfer;
  logic [SH_W-1:0] sh_data;
  logic            sh_last;
  logic            sh_full;
  logic            check_ok;
  logic            commit;

  assign transfer = key_valid_i & ready_reg;

  camo_key_shift #(
    .WIDTH (SH_W)
  ) u_shift (
    .clk    (clk),
    .rst    (rst),
    .clr    (sh_clr),
    .wr_en  (transfer),
    .bit_in (key_bit_i),
    .data   (sh_data),
    .last   (sh_last),
    .full   (sh_full)
  );

  always_comb begin
    state_next = state_reg;
    sh_clr     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (load_start_i) begin
          state_next = S_LOAD;
          sh_clr     = 1'b1;
        end else if (lock_i) begin
          state_next = S_LOCKED;
        end
      end
      S_LOAD: begin
        // A restart wins over a bit arriving in the same cycle.
        if (load_start_i) begin
          sh_clr = 1'b1;
        end else if (transfer && sh_last) begin
          state_next = S_CHECK;
        end
      end
      S_CHECK:  state_next = S_IDLE;
      S_LOCKED: state_next = S_LOCKED;
      default:  state_next = S_IDLE;
    endcase
  end

`ifdef CAMO_KEY_PARITY_EN
  logic err_reg;
  logic check_fail;

  assign check_ok   = sh_full & ~(^sh_data);
  assign check_fail = (state_reg == S_CHECK) & ~check_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (sh_clr) begin
      err_reg <= 1'b0;
    end else if (check_fail) begin
      err_reg <= 1'b1;
    end
  end

  assign err_o = err_reg;
`else
  assign check_ok = sh_full;
  assign err_o    = 1'b0;
`endif

  assign commit = (state_reg == S_CHECK) & check_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      ready_reg  <= 1'b0;
      key_reg    <= '0;
      done_reg   <= 1'b0;
      locked_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      ready_reg  <= (state_next == S_LOAD);
      done_reg   <= commit;
      locked_reg <= (state_next == S_LOCKED);
      if (commit) begin
        key_reg <= sh_data[KEY_W-1:0];
      end
    end
  end

  assign key_ready_o = ready_reg;
  assign key_o       = key_reg;
  assign busy_o      = (state_reg == S_LOAD) || (state_reg == S_CHECK);
  assign done_o      = done_reg;
  assign locked_o    = locked_reg;

endmodule

// File: tb/tb_camo_key_loader.sv
// Directed bench for camo_key_loader with N_CELLS=2; adapts to CAMO_KEY_PARITY_EN.
module tb_camo_key_loader;

  localparam int N     = 2;
  localparam int KEY_W = 2 * N;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_start_i;
  logic             key_valid_i;
  logic             key_bit_i;
  logic             key_ready_o;
  logic             lock_i;
  logic [KEY_W-1:0] key_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic             locked_o;

  int checks = 0;
  int errors = 0;
  logic [KEY_W-1:0] model_key;

  camo_key_loader #(.N_CELLS(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_start_i (load_start_i),
    .key_valid_i  (key_valid_i),
    .key_bit_i    (key_bit_i),
    .key_ready_o  (key_ready_o),
    .lock_i       (lock_i),
    .key_o        (key_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .locked_o     (locked_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [KEY_W-1:0] bits;     // bits[j] is the j-th serial bit (D_j)
    bit               bp;       // insert a valid=0 cycle between bits
    logic [KEY_W-1:0] exp_key;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic [KEY_W-1:0] bits, input bit bp, input bit bad_par);
    logic [KEY_W:0] stream;
    int nb;
    stream = {1'b0, bits};
    nb = KEY_W;
`ifdef CAMO_KEY_PARITY_EN
    stream[KEY_W] = (^bits) ^ bad_par;
    nb = KEY_W + 1;
`endif
    for (int i = 0; i < nb; i++) begin
      key_valid_i = 1'b1;
      key_bit_i   = stream[i];
      tick();
      if (bp && i < nb - 1) begin
        key_valid_i = 1'b0;
        key_bit_i   = ~stream[i];
        tick();
      end
    end
    key_valid_i = 1'b0;
    key_bit_i   = 1'b0;
  endtask

  // Full load from IDLE; checks no partial key, commit one edge after the final accept.
  task automatic run_load(input string name, input logic [KEY_W-1:0] bits, input bit bp,
                          input bit bad_par, input logic [KEY_W-1:0] exp_key);
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    chk({name, "_ready"}, key_ready_o, 1);
    chk({name, "_err_clr"}, err_o, 0);
    send_bits(bits, bp, bad_par);
    chk({name, "_check_busy"}, {key_ready_o, busy_o}, 2'b01);
    chk({name, "_no_partial"}, key_o, model_key);
    tick();
    chk({name, "_key"}, key_o, exp_key);
    chk({name, "_done"}, done_o, !bad_par);
    chk({name, "_err"}, err_o, bad_par);
    chk({name, "_idle"}, busy_o, 0);
    model_key = exp_key;
    tick();
    chk({name, "_done_end"}, done_o, 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{"v_1011",    4'b1101, 1'b0, 4'b1101};
    vecs[1] = '{"v_bp_1011", 4'b1101, 1'b1, 4'b1101};
    vecs[2] = '{"v_0100",    4'b0010, 1'b0, 4'b0010};
    vecs[3] = '{"v_0111",    4'b1110, 1'b1, 4'b1110};
    vecs[4] = '{"v_0000",    4'b0000, 1'b0, 4'b0000};

    rst = 1'b1; load_start_i = 0; key_valid_i = 0; key_bit_i = 0; lock_i = 0;
    model_key = '0;
    tick(); tick();
    chk("reset_outputs", {key_o, key_ready_o, busy_o, done_o, err_o, locked_o}, 0);
    rst = 1'b0;
    tick();

    // valid outside LOAD must not be consumed
    key_valid_i = 1'b1; key_bit_i = 1'b1;
    tick(); tick();
    chk("idle_valid_ignored", {key_ready_o, busy_o}, 0);
    key_valid_i = 1'b0; key_bit_i = 1'b0;

    for (int v = 0; v < 5; v++)
      run_load(vecs[v].name, vecs[v].bits, vecs[v].bp, 1'b0, vecs[v].exp_key);

    // start+lock together: start wins; then restart mid-load
    load_start_i = 1'b1; lock_i = 1'b1;
    tick();
    load_start_i = 1'b0; lock_i = 1'b0;
    chk("start_over_lock", {locked_o, key_ready_o}, 2'b01);
    key_valid_i = 1'b1; key_bit_i = 1'b1; tick();
    key_bit_i = 1'b1; tick();
    key_valid_i = 1'b0;
    run_load("restart", 4'b0010, 1'b0, 1'b0, 4'b0010);

`ifdef CAMO_KEY_PARITY_EN
    run_load("par_good", 4'b1101, 1'b0, 1'b0, 4'b1101);
    run_load("par_bad", 4'b1101, 1'b0, 1'b1, 4'b1101);
    run_load("par_bad2", 4'b0010, 1'b0, 1'b1, 4'b1101);
    run_load("par_recover", 4'b0010, 1'b0, 1'b0, 4'b0010);
`endif

    // async reset mid-load
    load_start_i = 1'b1; tick(); load_start_i = 1'b0;
    key_valid_i = 1'b1; key_bit_i = 1'b1; tick(); tick();
    key_valid_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_midload", {key_o, key_ready_o, busy_o, done_o, err_o, locked_o}, 0);
    model_key = '0;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_idle", {key_ready_o, busy_o}, 0);
    run_load("after_rst", 4'b1101, 1'b0, 1'b0, 4'b1101);

    // lock then attempt a reload
    lock_i = 1'b1; tick(); lock_i = 1'b0;
    chk("locked", {locked_o, key_ready_o, busy_o}, 3'b100);
    load_start_i = 1'b1; tick(); load_start_i = 1'b0;
    chk("locked_no_start", {key_ready_o, busy_o}, 0);
    send_bits(4'b0000, 1'b0, 1'b0);
    tick();
    chk("locked_key_frozen", key_o, model_key);
    chk("locked_no_done", {done_o, locked_o}, 2'b01);

    // async reset while locked
    rst = 1'b1;
    #1;
    chk("rst_locked", {key_o, key_ready_o, busy_o, done_o, err_o, locked_o}, 0);
    tick();
    rst = 1'b0;
    model_key = '0;
    tick();
    run_load("unlock_load", 4'b0010, 1'b0, 1'b0, 4'b0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
